instr_fetch_queue: RTL and testbench



---
 rtl/instr_fetch_queue_pkg.sv | 22 ++
 rtl/ifq_fifo.sv | 54 +++++
 rtl/instr_fetch_queue.sv | 92 +++++++++
 tb/tb_instr_fetch_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch stage: fetch FSM states,
// queue entry layout and HALT decoding.
package instr_fetch_queue_pkg;

  localparam logic [5:0]  HALT_OPCODE = 6'b111111;
  localparam logic [31:0] WORD_BYTES  = 32'd4;

  typedef enum logic {
    Fetch = 1'b0,
    Stop  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } ifq_entry_t;

  function automatic logic is_halt(input logic [31:0] word);
    return word[31:26] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry FIFO of {word, pc} entries with synchronous flush.
// The caller guarantees no push when full and no pop when empty.
module ifq_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  ifq_entry_t               i_push_entry,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output ifq_entry_t               o_head_entry
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  ifq_entry_t      r_mem [DEPTH];
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_push_entry;
  end

  assign o_count      = r_count;
  assign o_head_entry = r_mem[r_head];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, strobes the combinational ROM and queues fetched words.
// Define IFQ_HALT_DETECT_EN to stop fetching after a HALT word is queued.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned PC_LIMIT = 100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_rom_addr,
  output logic        o_rom_nrd,
  input  logic [31:0] i_rom_data,
  output logic        o_inst_valid,
  output logic [31:0] o_inst_data,
  output logic [31:0] o_inst_pc,
  input  logic        i_issue_ready,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_halted
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [31:0]     r_pc;
  logic [31:0]     w_pc_next;
  logic [CntW-1:0] w_count;
  ifq_entry_t      w_head;
  ifq_entry_t      w_push_entry;
  logic            w_pc_in_range;
  logic            w_fetch_fire;
  logic            w_inst_valid;
  logic            w_pop;

  // 33-bit compare so a PC near 2^32 cannot wrap back into range.
  assign w_pc_in_range = ({1'b0, r_pc} + {1'b0, WORD_BYTES}) <= 33'(PC_LIMIT);
  // Full-queue test uses the registered count only, keeping issue_ready off the strobe.
  assign w_fetch_fire  = !i_rst && (r_state == Fetch) && (w_count < CntW'(DEPTH)) &&
                         w_pc_in_range && !i_redirect_valid;
  assign w_inst_valid  = (w_count != '0);
  assign w_pop         = w_inst_valid && i_issue_ready && !i_redirect_valid;
  assign w_push_entry  = '{data: i_rom_data, pc: r_pc};

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (w_fetch_fire),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (i_redirect_valid),
    .o_count      (w_count),
    .o_head_entry (w_head)
  );

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (i_redirect_valid) begin
      w_pc_next    = {i_redirect_pc[31:2], 2'b00};
      w_state_next = Fetch;
    end else begin
      if (w_fetch_fire) w_pc_next = r_pc + WORD_BYTES;
      if ((r_state == Fetch) && !w_pc_in_range) w_state_next = Stop;
`ifdef IFQ_HALT_DETECT_EN
      if (w_fetch_fire && is_halt(i_rom_data)) w_state_next = Stop;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= Fetch;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  assign o_rom_addr   = r_pc;
  assign o_rom_nrd    = !w_fetch_fire;
  assign o_inst_valid = w_inst_valid;
  assign o_inst_data  = w_inst_valid ? w_head.data : 32'h0;
  assign o_inst_pc    = w_inst_valid ? w_head.pc : 32'h0;
  assign o_halted     = (r_state == Stop);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH=4, PC_LIMIT=100).
// Builds with or without IFQ_HALT_DETECT_EN; the HALT step checks whichever applies.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic        rom_nrd;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        issue_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  logic [31:0] rom_mem [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr[6:2]];

  instr_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0),
    .PC_LIMIT (100)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_rom_addr       (rom_addr),
    .o_rom_nrd        (rom_nrd),
    .i_rom_data       (rom_data),
    .o_inst_valid     (inst_valid),
    .o_inst_data      (inst_data),
    .o_inst_pc        (inst_pc),
    .i_issue_ready    (issue_ready),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one tick into the first cycle after reset release.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    issue_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          issued;
    logic [31:0] exp_pc;
    logic [31:0] last_fetch;

    for (int i = 0; i < 32; i++) rom_mem[i] = 32'hA500_0000 + 32'(i * 4);
    rom_mem[0] = 32'h1111_1111;
    rom_mem[1] = 32'h2222_2222;

    rst            = 1'b1;
    issue_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #3;
    chk("rst_nrd", 32'(rom_nrd), 32'd1);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Basic fetch-to-issue latency.
    @(posedge clk);
    #1;
    rst         = 1'b0;
    issue_ready = 1'b1;
    #1;
    chk("t1_c1_nrd", 32'(rom_nrd), 32'd0);
    chk("t1_c1_addr", rom_addr, 32'h0);
    step();
    chk("t1_c2_valid", 32'(inst_valid), 32'd1);
    chk("t1_c2_data", inst_data, 32'h1111_1111);
    chk("t1_c2_pc", inst_pc, 32'h0);
    step();
    chk("t1_c3_data", inst_data, 32'h2222_2222);
    chk("t1_c3_pc", inst_pc, 32'h4);

    // Fill the queue, then drain; fetch resumes one cycle after the first pop.
    do_reset();
    repeat (4) step();
    chk("t2_full_nrd", 32'(rom_nrd), 32'd1);
    chk("t2_full_addr", rom_addr, 32'd16);
    chk("t2_full_head", inst_pc, 32'h0);
    issue_ready = 1'b1;
    #1;
    chk("t2_popcyc_nrd", 32'(rom_nrd), 32'd1);
    step();
    chk("t2_resume_nrd", 32'(rom_nrd), 32'd0);
    chk("t2_resume_head", inst_pc, 32'h4);
    chk("t2_resume_addr", rom_addr, 32'd16);
    step();
    chk("t2_drain_head", inst_pc, 32'h8);
    chk("t2_drain_data", inst_data, 32'hA500_0008);
    chk("t2_drain_addr", rom_addr, 32'd20);

    // Redirect with three entries queued.
    do_reset();
    repeat (3) step();
    chk("t3_pre_addr", rom_addr, 32'd12);
    chk("t3_pre_valid", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_002B;
    #1;
    chk("t3_redir_nrd", 32'(rom_nrd), 32'd1);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t3_t1_valid", 32'(inst_valid), 32'd0);
    chk("t3_t1_addr", rom_addr, 32'h28);
    chk("t3_t1_nrd", 32'(rom_nrd), 32'd0);
    step();
    chk("t3_t2_valid", 32'(inst_valid), 32'd1);
    chk("t3_t2_pc", inst_pc, 32'h28);
    chk("t3_t2_data", inst_data, 32'hA500_0028);

    // Run to PC_LIMIT with continuous issue.
    do_reset();
    issue_ready = 1'b1;
    #1;
    issued     = 0;
    exp_pc     = 32'h0;
    last_fetch = 32'hFFFF_FFFF;
    for (int c = 0; c < 40; c++) begin
      if (!rom_nrd) last_fetch = rom_addr;
      if (inst_valid) begin
        chk("t4_issue_pc", inst_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        issued++;
      end
      step();
    end
    chk("t4_issued", 32'(issued), 32'd25);
    chk("t4_last_fetch", last_fetch, 32'd96);
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_nrd", 32'(rom_nrd), 32'd1);
    chk("t4_addr", rom_addr, 32'd100);
    chk("t4_valid", 32'(inst_valid), 32'd0);

    // Asynchronous reset with two entries queued and a pop pending.
    do_reset();
    repeat (2) step();
    chk("t5_pre_valid", 32'(inst_valid), 32'd1);
    chk("t5_pre_addr", rom_addr, 32'd8);
    issue_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(inst_valid), 32'd0);
    chk("t5_async_addr", rom_addr, 32'h0);
    chk("t5_async_nrd", 32'(rom_nrd), 32'd1);
    chk("t5_async_data", inst_data, 32'h0);

    // HALT word at address 8.
    rom_mem[2] = 32'hFC00_0000;
    do_reset();
    issue_ready = 1'b1;
    repeat (3) step();
    chk("t6_head_pc", inst_pc, 32'h8);
    chk("t6_head_data", inst_data, 32'hFC00_0000);
    chk("t6_addr", rom_addr, 32'd12);
`ifdef IFQ_HALT_DETECT_EN
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_nrd", 32'(rom_nrd), 32'd1);
    step();
    chk("t6_hold_addr", rom_addr, 32'd12);
    chk("t6_hold_valid", 32'(inst_valid), 32'd0);
    chk("t6_hold_halted", 32'(halted), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t6_redir_halted", 32'(halted), 32'd0);
    chk("t6_redir_nrd", 32'(rom_nrd), 32'd0);
`else
    chk("t6_halted", 32'(halted), 32'd0);
    chk("t6_nrd", 32'(rom_nrd), 32'd0);
    step();
    chk("t6_next_addr", rom_addr, 32'd16);
    chk("t6_next_pc", inst_pc, 32'd12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
